seg7_capture_decoder: RTL and testbench

SEG7_CAPTURE_DECODER -- requirements
Module: seg7_capture_decoder

---
 rtl/seg7_capture_decoder.sv | 170 +++++++++++++++++
 tb/tb_seg7_capture_decoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture_decoder.sv
// Captures a multiplexed, active-low 7-segment display bus and converts each
// digit into BCD once its segment/select pair has been seen stable long enough.
module seg7_capture_decoder #(
   parameter int NUM_DIG    = 8,
   parameter int STABLE_CYC = 4
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   sample_en,
   input  logic [6:0]             seg_in,
   input  logic [NUM_DIG-1:0]     dig_sel,
   input  logic                   clr_err,
   output logic [4*NUM_DIG-1:0]   bcd_out,
   output logic [NUM_DIG-1:0]     digit_valid,
   output logic                   err_pulse,
   output logic                   err_sticky,
   output logic                   frame_done
);

   localparam logic [3:0]         STABLE_MAX = 4'(STABLE_CYC);
   localparam logic [3:0]         STABLE_PRE = 4'(STABLE_CYC - 1);
   localparam logic [6:0]         SEG_BLANK  = 7'b1111111;
   localparam logic [NUM_DIG-1:0] SEL_ONE    = NUM_DIG'(1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [6:0]           last_seg_q, last_seg_d;
   logic [NUM_DIG-1:0]   last_sel_q, last_sel_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [4*NUM_DIG-1:0] bcd_q, bcd_d;
   logic [NUM_DIG-1:0]   valid_q, valid_d;
   logic [NUM_DIG-1:0]   mask_q, mask_d;
   logic                 err_pulse_q, err_pulse_d;
   logic                 err_sticky_q, err_sticky_d;
   logic                 frame_done_q, frame_done_d;

   // ------------------------------------------------------------------
   // Input qualification
   // ------------------------------------------------------------------
   logic [NUM_DIG-1:0]   sel_minus_one;
   logic                 sel_onehot;
   logic                 pair_match;
   logic                 commit;

   assign sel_minus_one = dig_sel - SEL_ONE;
   assign sel_onehot    = (dig_sel != '0) && ((dig_sel & sel_minus_one) == '0);
   assign pair_match    = (seg_in == last_seg_q) && (dig_sel == last_sel_q);

   // Stability tracking: a commit fires only on the S-1 -> S transition,
   // so a held pattern commits exactly once per dwell.
   always_comb begin
      last_seg_d = last_seg_q;
      last_sel_d = last_sel_q;
      cnt_d      = cnt_q;
      commit     = 1'b0;
      if (sample_en) begin
         if (!sel_onehot) begin
            cnt_d      = 4'd0;
            last_seg_d = SEG_BLANK;
            last_sel_d = '0;
         end else if (pair_match) begin
            if (cnt_q < STABLE_MAX) begin
               cnt_d = cnt_q + 4'd1;
            end
            commit = (cnt_q == STABLE_PRE);
         end else begin
            last_seg_d = seg_in;
            last_sel_d = dig_sel;
            cnt_d      = 4'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Segment pattern decode
   // ------------------------------------------------------------------
   logic [3:0] dec_bcd;
   logic       dec_legal;
   logic       dec_err;

   always_comb begin
      dec_bcd   = 4'hF;
      dec_legal = 1'b0;
      dec_err   = 1'b0;
      case (seg_in)
         7'b1000000: begin dec_bcd = 4'd0; dec_legal = 1'b1; end
         7'b1111001: begin dec_bcd = 4'd1; dec_legal = 1'b1; end
         7'b0100100: begin dec_bcd = 4'd2; dec_legal = 1'b1; end
         7'b0110000: begin dec_bcd = 4'd3; dec_legal = 1'b1; end
         7'b0011001: begin dec_bcd = 4'd4; dec_legal = 1'b1; end
         7'b0010010: begin dec_bcd = 4'd5; dec_legal = 1'b1; end
         7'b0000010: begin dec_bcd = 4'd6; dec_legal = 1'b1; end
         7'b1111000: begin dec_bcd = 4'd7; dec_legal = 1'b1; end
         7'b0000000: begin dec_bcd = 4'd8; dec_legal = 1'b1; end
         7'b0010000: begin dec_bcd = 4'd9; dec_legal = 1'b1; end
         7'b1111111: begin dec_bcd = 4'hF; dec_legal = 1'b0; end
         default:    begin dec_err = 1'b1; end
      endcase
   end

   // ------------------------------------------------------------------
   // Per-digit capture registers: only the selected digit is rewritten
   // ------------------------------------------------------------------
   logic [NUM_DIG-1:0] dig_wr;

   for (genvar gi = 0; gi < NUM_DIG; gi++) begin : g_dig
      assign dig_wr[gi]          = commit & dig_sel[gi];
      assign bcd_d[gi*4 +: 4]    = dig_wr[gi] ? dec_bcd   : bcd_q[gi*4 +: 4];
      assign valid_d[gi]         = dig_wr[gi] ? dec_legal : valid_q[gi];
   end

   // ------------------------------------------------------------------
   // Frame mask, error flags
   // ------------------------------------------------------------------
   // A full mask is only ever seen on the edge right after a commit, when no
   // new commit is possible, so clearing it cannot drop a committed digit.
   always_comb begin
      mask_d       = mask_q;
      frame_done_d = 1'b0;
      err_pulse_d  = 1'b0;
      err_sticky_d = err_sticky_q;
      if (sample_en) begin
         if (&mask_q) begin
            mask_d       = '0;
            frame_done_d = 1'b1;
         end else if (commit) begin
            mask_d = mask_q | dig_sel;
         end
      end
      if (clr_err) begin
         err_sticky_d = 1'b0;
      end
      if (commit && dec_err) begin
         err_pulse_d  = 1'b1;
         err_sticky_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         last_seg_q   <= SEG_BLANK;
         last_sel_q   <= '0;
         cnt_q        <= 4'd0;
         bcd_q        <= '0;
         valid_q      <= '0;
         mask_q       <= '0;
         err_pulse_q  <= 1'b0;
         err_sticky_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         last_seg_q   <= last_seg_d;
         last_sel_q   <= last_sel_d;
         cnt_q        <= cnt_d;
         bcd_q        <= bcd_d;
         valid_q      <= valid_d;
         mask_q       <= mask_d;
         err_pulse_q  <= err_pulse_d;
         err_sticky_q <= err_sticky_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bcd_out     = bcd_q;
   assign digit_valid = valid_q;
   assign err_pulse   = err_pulse_q;
   assign err_sticky  = err_sticky_q;
   assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Bench for seg7_capture_decoder: directed scenarios followed by random
// dwells, every cycle compared against a run-length reference model.
module tb_seg7_capture_decoder;

   localparam int ND = 8;
   localparam int SC = 4;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          sample_en = 1'b0;
   logic [6:0]    seg_in = 7'h7F;
   logic [ND-1:0] dig_sel = '0;
   logic          clr_err = 1'b0;
   logic [4*ND-1:0] bcd_out;
   logic [ND-1:0] digit_valid;
   logic          err_pulse;
   logic          err_sticky;
   logic          frame_done;

   int checks = 0;
   int failures = 0;

   seg7_capture_decoder #(.NUM_DIG(ND), .STABLE_CYC(SC)) dut (
      .clk(clk), .rstn(rstn), .sample_en(sample_en), .seg_in(seg_in),
      .dig_sel(dig_sel), .clr_err(clr_err), .bcd_out(bcd_out),
      .digit_valid(digit_valid), .err_pulse(err_pulse),
      .err_sticky(err_sticky), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Digit glyphs 0..9, active-low, bit6=g .. bit0=a
   bit [6:0] pats [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000};

   // Reference model: counts the length of the current run of identical
   // one-hot samples; a digit is captured when the run reaches SC.
   int       run_len;
   int       run_dig;
   bit [6:0] run_seg;
   bit [3:0] m_bcd [ND];
   bit       m_valid [ND];
   bit       m_seen [ND];
   bit       m_errp, m_sticky, m_frame;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int glyph_value(input bit [6:0] s);
      for (int k = 0; k < 10; k++) if (pats[k] == s) return k;
      return (s == 7'h7F) ? -1 : -2;
   endfunction

   task automatic model_reset();
      run_len = 0; run_dig = -1; run_seg = 7'h7F;
      for (int i = 0; i < ND; i++) begin m_bcd[i] = 0; m_valid[i] = 0; m_seen[i] = 0; end
      m_errp = 0; m_sticky = 0; m_frame = 0;
   endtask

   task automatic model_step(input bit se, input bit [6:0] s, input bit [ND-1:0] d, input bit c);
      bit all_seen;
      int dig;
      int v;
      m_errp = 0; m_frame = 0;
      if (c) m_sticky = 0;
      if (!se) return;
      all_seen = 1;
      for (int i = 0; i < ND; i++) all_seen &= m_seen[i];
      if (all_seen) begin
         m_frame = 1;
         for (int i = 0; i < ND; i++) m_seen[i] = 0;
      end
      if ($countones(d) != 1) begin
         run_len = 0; run_dig = -1;
         return;
      end
      dig = 0;
      for (int i = 0; i < ND; i++) if (d[i]) dig = i;
      if (dig == run_dig && s == run_seg) run_len++;
      else begin run_dig = dig; run_seg = s; run_len = 1; end
      if (run_len == SC) begin
         v = glyph_value(s);
         m_seen[dig] = 1;
         if (v >= 0) begin m_bcd[dig] = 4'(v); m_valid[dig] = 1; end
         else begin
            m_bcd[dig] = 4'hF; m_valid[dig] = 0;
            if (v == -2) begin m_errp = 1; m_sticky = 1; end
         end
      end
   endtask

   task automatic compare_all();
      logic [4*ND-1:0] eb;
      logic [ND-1:0]   ev;
      for (int i = 0; i < ND; i++) begin eb[i*4 +: 4] = m_bcd[i]; ev[i] = m_valid[i]; end
      chk("bcd_out", 64'(bcd_out), 64'(eb));
      chk("digit_valid", 64'(digit_valid), 64'(ev));
      chk("err_pulse", 64'(err_pulse), 64'(m_errp));
      chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
      chk("frame_done", 64'(frame_done), 64'(m_frame));
   endtask

   // One clock: drive at negedge, update model at posedge, compare 1ns later.
   task automatic step(input bit rst, input bit se, input bit [6:0] s,
                       input bit [ND-1:0] d, input bit c);
      @(negedge clk);
      rstn = ~rst; sample_en = se; seg_in = s; dig_sel = d; clr_err = c;
      @(posedge clk);
      if (rst) model_reset();
      else model_step(se, s, d, c);
      #1;
      compare_all();
   endtask

   initial begin
      model_reset();
      step(1, 0, 7'h7F, 8'h00, 0);
      chk("reset_bcd", 64'(bcd_out), 64'h0);
      chk("reset_flags", 64'({digit_valid, err_pulse, err_sticky, frame_done}), 64'h0);

      // Digit 2 shows "2" for 4 sampled cycles, then held
      for (int i = 0; i < 4; i++) step(0, 1, 7'b0100100, 8'h04, 0);
      chk("d2_bcd", 64'(bcd_out[11:8]), 64'd2);
      chk("d2_valid", 64'(digit_valid[2]), 64'd1);
      for (int i = 0; i < 3; i++) step(0, 1, 7'b0100100, 8'h04, 0);

      // Broken dwell on digit 5: 3 + gap + 3 gives no capture
      for (int i = 0; i < 3; i++) step(0, 1, 7'b0011001, 8'h20, 0);
      step(0, 1, 7'b0011001, 8'h00, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 7'b0011001, 8'h20, 0);
      chk("gap_valid5", 64'(digit_valid[5]), 64'd0);

      // Full scan after reset: digits 0..7 show 7..0
      step(1, 0, 7'h7F, 8'h00, 0);
      for (int k = 0; k < ND; k++)
         for (int i = 0; i < 4; i++) step(0, 1, pats[7-k], 8'(1 << k), 0);
      chk("scan_frame_early", 64'(frame_done), 64'd0);
      step(0, 1, pats[0], 8'h80, 0);
      chk("scan_bcd", 64'(bcd_out), 64'h01234567);
      chk("scan_valid", 64'(digit_valid), 64'hFF);
      chk("scan_frame", 64'(frame_done), 64'd1);
      step(0, 1, pats[0], 8'h80, 0);
      chk("scan_frame_once", 64'(frame_done), 64'd0);

      // Illegal glyph on digit 0, then clear
      for (int i = 0; i < 4; i++) step(0, 1, 7'b0101010, 8'h01, 0);
      chk("ill_pulse", 64'(err_pulse), 64'd1);
      chk("ill_sticky", 64'(err_sticky), 64'd1);
      chk("ill_bcd", 64'(bcd_out[3:0]), 64'hF);
      chk("ill_valid", 64'(digit_valid[0]), 64'd0);
      step(0, 1, 7'b0101010, 8'h01, 0);
      chk("ill_pulse_once", 64'(err_pulse), 64'd0);
      step(0, 1, 7'b0101010, 8'h01, 1);
      chk("clr_sticky", 64'(err_sticky), 64'd0);

      // Reset mid-dwell, then 4 fresh samples required
      for (int i = 0; i < 2; i++) step(0, 1, pats[3], 8'h08, 0);
      step(1, 1, pats[3], 8'h08, 0);
      for (int i = 0; i < 3; i++) step(0, 1, pats[3], 8'h08, 0);
      chk("rst_no_commit", 64'(digit_valid[3]), 64'd0);
      step(0, 1, pats[3], 8'h08, 0);
      chk("rst_commit", 64'(bcd_out[15:12]), 64'd3);

      // Gated sampling with a blank glyph on digit 6
      for (int i = 0; i < 8; i++) step(0, (i % 2) == 0, 7'h7F, 8'h40, 0);
      chk("blank_bcd", 64'(bcd_out[27:24]), 64'hF);
      chk("blank_err", 64'({digit_valid[6], err_sticky}), 64'd0);

      // Random dwells
      for (int n = 0; n < 400; n++) begin
         bit [6:0]    s;
         bit [ND-1:0] d;
         int          len;
         int          r;
         r = $urandom_range(0, 99);
         if (r < 70)      s = pats[$urandom_range(0, 9)];
         else if (r < 80) s = 7'h7F;
         else             s = 7'($urandom_range(0, 127));
         r = $urandom_range(0, 99);
         if (r < 85)      d = 8'(1 << $urandom_range(0, ND - 1));
         else if (r < 93) d = 8'h00;
         else             d = 8'($urandom_range(0, 255));
         len = $urandom_range(1, 7);
         for (int i = 0; i < len; i++)
            step($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 80, s, d,
                 $urandom_range(0, 99) < 5);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
